// File: rtl/instr_sequencer.sv
// Program sequencer feeding the control decoder's Instrucao input: holds a small
// writable opcode program and issues it one word per clock until END, stop or the last address.
//
// state | meaning
// IDLE  | program writable, waiting for start
// RUN   | fetching mem[pc] and issuing one opcode per clock
// DONE  | single-cycle completion pulse, returns to IDLE
module instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [2:0]    prog_data,
    input  logic          start,
    input  logic          stop,
    output logic [2:0]    Instrucao,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc
);

    localparam logic [2:0]    NOP     = 3'b111;
    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] pc_q, pc_nxt;
    logic [2:0]    instr_q, instr_nxt;
    logic          valid_q, valid_nxt;
    logic [2:0]    mem [DEPTH];
    logic [2:0]    fetch;
    logic          fetch_end;
    logic          mem_we;

    assign fetch     = mem[pc_q];
    // 101..111 all terminate the program
    assign fetch_end = fetch[2] & (fetch[1] | fetch[0]);
    assign mem_we    = (state == IDLE) && prog_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= NOP;
            end
        end else if (mem_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc_q    <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
            valid_q <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        instr_nxt = instr_q;
        valid_nxt = valid_q;
        case (state)
            IDLE: begin
                instr_nxt = NOP;
                valid_nxt = 1'b0;
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                end
            end
            RUN: begin
                if (stop || fetch_end) begin
                    state_nxt = DONE;
                    instr_nxt = NOP;
                    valid_nxt = 1'b0;
                end else begin
                    instr_nxt = fetch;
                    valid_nxt = 1'b1;
                    // last word: finish without wrapping pc back to 0
                    if (pc_q == PC_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        pc_nxt = pc_q + AW'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                instr_nxt = NOP;
                valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                instr_nxt = NOP;
                valid_nxt = 1'b0;
            end
        endcase
    end

    assign Instrucao = instr_q;
    assign valid     = valid_q;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign pc        = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus random programs
// compared against a list-based model of which opcodes a run should issue.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [2:0] prog_data;
    logic       start;
    logic       stop;
    logic [2:0] Instrucao;
    logic       valid;
    logic       busy;
    logic       done;
    logic [3:0] pc;

    int errors = 0;
    int checks = 0;

    logic [2:0] model_mem [16];
    logic [2:0] obs_q [$];
    logic [2:0] exp_q [$];
    int         exp_done;
    int         exp_pc;
    int         done_cyc;
    int         done_cnt;
    int         idle_cyc;
    int         busy_cnt;
    logic       done_valid;
    logic       busy_e0;

    instr_sequencer #(.DEPTH(16), .AW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .stop      (stop),
        .Instrucao (Instrucao),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    // Expected issue list: words in address order up to the first END, cut short
    // after s issues when a stop is requested.
    function automatic void build_expect(input int s);
        exp_q.delete();
        for (int a = 0; a < 16; a++) begin
            if (model_mem[a] >= 3'd5) break;
            if (s > 0 && exp_q.size() == s) break;
            exp_q.push_back(model_mem[a]);
        end
        exp_done = (exp_q.size() == 16) ? 16 : exp_q.size() + 1;
        exp_pc   = (exp_q.size() == 16) ? 15 : exp_q.size();
    endfunction

    task automatic write_word(input int a, input logic [2:0] d);
        prog_we   = 1'b1;
        prog_addr = a[3:0];
        prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
        model_mem[a] = d;
    endtask

    // Pulses start and records what the DUT does, cycle by cycle, until it is idle again.
    task automatic run_prog(input int stop_after, input bit disturb,
                            input bit wr0, input logic [2:0] wr0_data);
        bit stop_sent = 1'b0;
        obs_q.delete();
        done_cyc   = -1;
        idle_cyc   = -1;
        done_cnt   = 0;
        busy_cnt   = 0;
        done_valid = 1'b0;
        start = 1'b1;
        if (wr0) begin
            prog_we   = 1'b1;
            prog_addr = 4'd0;
            prog_data = wr0_data;
            model_mem[0] = wr0_data;
        end
        @(negedge clk);
        start   = 1'b0;
        prog_we = 1'b0;
        busy_e0 = busy;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            stop    = 1'b0;
            prog_we = 1'b0;
            start   = 1'b0;
            if (valid) obs_q.push_back(Instrucao);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
                if (valid) done_valid = 1'b1;
            end
            if (stop_after > 0 && obs_q.size() == stop_after && !stop_sent) begin
                stop      = 1'b1;
                stop_sent = 1'b1;
            end
            if (disturb && k == 1) begin
                prog_we   = 1'b1;
                prog_addr = 4'd2;
                prog_data = 3'b100;
                start     = 1'b1;
            end
            if (!busy && !done) begin
                idle_cyc = k;
                break;
            end
        end
        stop    = 1'b0;
        prog_we = 1'b0;
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (Instrucao !== 3'b111) begin errors++; $display("FAIL reset_instr: got %b expected 111", Instrucao); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (pc !== 4'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", pc); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty(input string tag);
        build_expect(0);
        run_prog(0, 1'b0, 1'b0, 3'b000);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL %s_issued: got %0d expected 0", tag, obs_q.size()); end
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL %s_done_cycle: got %0d expected 1", tag, done_cyc); end
        checks++; if (idle_cyc != 2) begin errors++; $display("FAIL %s_idle_cycle: got %0d expected 2", tag, idle_cyc); end
    endtask

    task automatic test_basic();
        logic [2:0] prog [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
        for (int a = 0; a < 6; a++) write_word(a, prog[a]);
        build_expect(0);
        run_prog(0, 1'b0, 1'b0, 3'b000);
        checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL basic_count: got %0d expected 5", obs_q.size()); end
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== prog[i]) begin errors++; $display("FAIL basic_op%0d: got %b expected %b", i, obs_q[i], prog[i]); end
        end
        checks++; if (busy_e0 !== 1'b1) begin errors++; $display("FAIL basic_busy_e0: got %b expected 1", busy_e0); end
        checks++; if (busy_cnt != 5) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 5", busy_cnt); end
        checks++; if (done_cyc != 6 || done_cnt != 1) begin errors++; $display("FAIL basic_done: got cycle %0d count %0d expected cycle 6 count 1", done_cyc, done_cnt); end
        checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL basic_done_valid: got %b expected 0", done_valid); end
        checks++; if (idle_cyc != 7) begin errors++; $display("FAIL basic_idle_cycle: got %0d expected 7", idle_cyc); end
        checks++; if (pc !== 4'd5) begin errors++; $display("FAIL basic_pc: got %0d expected 5", pc); end
    endtask

    task automatic test_full();
        for (int a = 0; a < 16; a++) write_word(a, 3'b010);
        run_prog(0, 1'b0, 1'b0, 3'b000);
        checks++; if (obs_q.size() != 16) begin errors++; $display("FAIL full_count: got %0d expected 16", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== 3'b010) begin errors++; $display("FAIL full_op%0d: got %b expected 010", i, obs_q[i]); end
        end
        checks++; if (done_cyc != 16 || done_valid !== 1'b1) begin errors++; $display("FAIL full_done: got cycle %0d valid %b expected cycle 16 valid 1", done_cyc, done_valid); end
        checks++; if (pc !== 4'd15) begin errors++; $display("FAIL full_pc: got %0d expected 15", pc); end
        checks++; if (Instrucao !== 3'b111 || valid !== 1'b0) begin errors++; $display("FAIL full_after: got %b/%b expected 111/0", Instrucao, valid); end
    endtask

    task automatic test_stop();
        for (int a = 0; a < 10; a++) write_word(a, 3'b001);
        write_word(10, 3'b111);
        build_expect(3);
        run_prog(3, 1'b0, 1'b0, 3'b000);
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL stop_count: got %0d expected 3", obs_q.size()); end
        checks++; if (done_cyc != 4 || done_cnt != 1) begin errors++; $display("FAIL stop_done: got cycle %0d count %0d expected cycle 4 count 1", done_cyc, done_cnt); end
        checks++; if (pc !== 4'(exp_pc)) begin errors++; $display("FAIL stop_pc: got %0d expected %0d", pc, exp_pc); end
    endtask

    task automatic test_ignore_in_run();
        for (int a = 0; a < 4; a++) write_word(a, 3'b001);
        write_word(4, 3'b111);
        run_prog(0, 1'b1, 1'b0, 3'b000);
        checks++; if (obs_q.size() != 4 || done_cyc != 5) begin errors++; $display("FAIL norestart: got %0d issues done at %0d expected 4 issues done at 5", obs_q.size(), done_cyc); end
        run_prog(0, 1'b0, 1'b0, 3'b000);
        checks++; if (obs_q.size() < 3 || obs_q[2] !== 3'b001) begin errors++; $display("FAIL runwrite_ignored: got size %0d expected mem[2]=001", obs_q.size()); end
    endtask

    task automatic test_write_start();
        run_prog(0, 1'b0, 1'b1, 3'b011);
        build_expect(0);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL wrstart_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        checks++; if (obs_q.size() == 0 || obs_q[0] !== 3'b011) begin errors++; $display("FAIL wrstart_first: got size %0d expected first 011", obs_q.size()); end
    endtask

    task automatic test_async_reset();
        for (int a = 0; a < 5; a++) write_word(a, 3'b010);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL arst_midrun: got valid %b busy %b expected 1 1", valid, busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (Instrucao !== 3'b111 || valid !== 1'b0) begin errors++; $display("FAIL arst_out: got %b/%b expected 111/0", Instrucao, valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pc !== 4'd0) begin errors++; $display("FAIL arst_state: got busy %b done %b pc %0d expected 0 0 0", busy, done, pc); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) model_mem[a] = 3'b111;
        @(negedge clk);
        test_empty("arst_empty");
    endtask

    task automatic test_random(input int iters);
        for (int it = 0; it < iters; it++) begin
            int end_pos = $urandom_range(0, 16);
            int s = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 17) : 0;
            for (int a = 0; a < 16; a++) begin
                logic [2:0] d;
                if (a < end_pos) d = 3'($urandom_range(0, 4));
                else if (a == end_pos) d = 3'($urandom_range(5, 7));
                else d = 3'($urandom_range(0, 7));
                write_word(a, d);
            end
            build_expect(s);
            run_prog(s, 1'b0, 1'b0, 3'b000);
            checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d expected %0d", it, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_op%0d: got %b expected %b", it, i, obs_q[i], exp_q[i]); end
            end
            checks++; if (done_cyc != exp_done || done_cnt != 1) begin errors++; $display("FAIL rnd%0d_done: got cycle %0d count %0d expected cycle %0d count 1", it, done_cyc, done_cnt, exp_done); end
            checks++; if (pc !== 4'(exp_pc)) begin errors++; $display("FAIL rnd%0d_pc: got %0d expected %0d", it, pc, exp_pc); end
            checks++; if (idle_cyc != exp_done + 1) begin errors++; $display("FAIL rnd%0d_idle: got %0d expected %0d", it, idle_cyc, exp_done + 1); end
        end
    endtask

    initial begin
        prog_we   = 1'b0;
        prog_addr = 4'd0;
        prog_data = 3'd0;
        start     = 1'b0;
        stop      = 1'b0;
        for (int a = 0; a < 16; a++) model_mem[a] = 3'b111;
        test_reset();
        test_empty("empty");
        test_basic();
        test_full();
        test_stop();
        test_ignore_in_run();
        test_write_start();
        test_async_reset();
        test_random(12);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program sequencer that sits directly upstream of the datapath control decoder and drives its 3-bit `Instrucao` input. It holds a small writable program of opcodes (clrld/addld/add/div2/disp) and, on `start`, issues them one per clock in address order until an END marker, a `stop` request, or the last address. It reports progress through `busy`/`done`/`valid` so a testbench or host can load a program, run it and wait for completion.

## Interface
- `DEPTH`, 16, number of program words (power of two, ≥2)
- `AW`, 4, address width, equals log2(DEPTH)

- `clk` in 1: single clock, all state updates on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `prog_we` in 1: program write enable, honoured only in IDLE
- `prog_addr` in AW: program write address
- `prog_data` in 3: opcode written to `prog_addr`
- `start` in 1: begin execution from address 0, honoured only in IDLE
- `stop` in 1: abort a running program
- `Instrucao` out 3: registered opcode to the control decoder
- `valid` out 1: registered; 1 when `Instrucao` carries an issued opcode
- `busy` out 1: 1 while state is RUN
- `done` out 1: 1 for exactly one cycle while state is DONE
- `pc` out AW: current fetch address

## Operation
- Opcodes: clrld 000, addld 001, add 010, div2 011, disp 100. Codes 101–111 are END markers. 111 is also the NOP value driven on `Instrucao` whenever nothing is issued.
- Program memory: DEPTH×3 register array. The write port is synchronous. The read port is combinational at `pc`.
- States: IDLE, RUN, DONE. `busy = (state==RUN)` and `done = (state==DONE)`, both decoded from the state register.
- IDLE:
  - `prog_we=1` writes `prog_data` to `mem[prog_addr]`.
  - `start=1` moves to RUN and sets `pc<=0`. `Instrucao` stays NOP and `valid` stays 0.
- RUN, evaluated each edge in this priority order:
  1. `stop=1` → DONE, `Instrucao<=NOP`, `valid<=0`.
  2. `mem[pc]` is END → DONE, `Instrucao<=NOP`, `valid<=0`. The END word is never issued.
  3. Otherwise `Instrucao<=mem[pc]` and `valid<=1`. If `pc==DEPTH-1`, go to DONE and leave `pc` unchanged (no wrap). Else `pc<=pc+1`.
- DONE: `Instrucao<=NOP`, `valid<=0`, next state IDLE. `pc` holds its final value until the next `start`.
- Writes (`prog_we`) in RUN or DONE are ignored. `start` outside IDLE is ignored.
- `start` and `prog_we` in the same IDLE cycle: the write lands and the run starts. The first fetch occurs on the following edge, so a write to address 0 is executed.
- Reset (`rst_n=0`), asynchronous and taking effect mid-run as well:
  - state IDLE, `pc=0`, `Instrucao=111`, `valid=0`, `busy=0`, `done=0`;
  - every memory word set to 111 (END).

## Timing
- Start latency: `start` sampled at edge E0 → first opcode on `Instrucao` after edge E0+1.
- Throughput: one opcode per cycle, no bubbles between consecutive opcodes.
- N opcodes followed by END (N<DEPTH):
  - `valid` high after edges E0+1 … E0+N;
  - END read at edge E0+N+1, after which `done` is high for one cycle;
  - IDLE after edge E0+N+2;
  - `busy` high after edges E0 … E0+N.
- Full program without END (DEPTH opcodes): the last opcode is issued at edge E0+DEPTH. `done` and `valid` are both high in that same cycle; NOP follows at the next edge.
- Empty program (`mem[0]` is END): `done` is high after edge E0+1 and no opcode is issued.
- `stop` sampled at edge S in RUN → NOP and `done` after edge S. An opcode already issued at edge S-1 remains issued.
- The decoder registers `Instrucao`, so its control outputs lag `Instrucao` by one more cycle. This block adds no further compensation.

## Test plan
- After reset: check `Instrucao=111`, `valid=0`, `busy=0`, `done=0`, `pc=0`. Then pulse `start` with the memory untouched → `done` one cycle after E0+1, `valid` never 1.
- Load [000,001,010,011,100,111] and pulse `start` → `Instrucao` 000,001,010,011,100 on consecutive cycles with `valid=1`, then NOP with `done=1` for one cycle, then IDLE.
- Load all 16 words with 010 (no END) → sixteen consecutive 010 issues, `done=1` coincident with the 16th, `pc=15`, no wrap to 0.
- Load [001×10,111] and assert `stop` at the edge after the 3rd issue → exactly 3 opcodes issued, then NOP and `done`.
- During RUN: apply `prog_we` to address 2 with data 100, and pulse `start` → memory unchanged and the run is not restarted. Same cycle in IDLE: `prog_we` to address 0 with 011 plus `start` → first issued opcode is 011.
- Drop `rst_n` mid-run (async, between edges) → outputs reset immediately. A following `start` with no reload → empty-program behaviour.
